sram_bus_arbiter: RTL and testbench

//  Shares one sram-like memory port between the instruction-fetch and data

---
 rtl/sram_bus_arbiter.sv | 118 +++++++++++
 tb/tb_sram_bus_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like port between the instruction and data requesters.
// Data wins by default; a streak counter guarantees a pending fetch gets served.
module sram_bus_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    typedef enum logic [2:0] {
        IDLE,
        REQ_I,
        REQ_D,
        RESP_I,
        RESP_D
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] streak, streak_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        streak_nxt   = streak;
        mem_req      = 1'b0;
        mem_wr       = 1'b0;
        mem_size     = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;

        case (state)
            IDLE: begin
                // Streak only grows while a fetch waits, so it saturates at STREAK_MAX.
                if (data_req && !(inst_req && streak == STREAK_MAX)) begin
                    state_nxt  = REQ_D;
                    streak_nxt = inst_req ? streak + SW'(1) : '0;
                end else if (inst_req) begin
                    state_nxt  = REQ_I;
                    streak_nxt = '0;
                end
            end
            REQ_I: begin
                mem_req      = 1'b1;
                mem_wr       = inst_wr;
                mem_size     = inst_size;
                mem_addr     = inst_addr;
                mem_wdata    = inst_wdata;
                inst_addr_ok = mem_addr_ok;
                if (mem_addr_ok) state_nxt = RESP_I;
            end
            REQ_D: begin
                mem_req      = 1'b1;
                mem_wr       = data_wr;
                mem_size     = data_size;
                mem_addr     = data_addr;
                mem_wdata    = data_wdata;
                data_addr_ok = mem_addr_ok;
                if (mem_addr_ok) state_nxt = RESP_D;
            end
            RESP_I: begin
                inst_data_ok = mem_data_ok;
                if (mem_data_ok) state_nxt = IDLE;
            end
            RESP_D: begin
                data_data_ok = mem_data_ok;
                if (mem_data_ok) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios plus random traffic against a
// transaction-level model of owner / accepted / streak.
module tb_sram_bus_arbiter;
    localparam int unsigned MAXS = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    sram_bus_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: who owns the port (0 none, 1 inst, 2 data), whether its address was taken.
    int m_owner = 0;
    bit m_acc = 1'b0;
    int m_streak = 0;
    bit keep_i = 1'b0, keep_d = 1'b0;
    int obs_grants[$];
    int cnt_iaok = 0, cnt_idok = 0, cnt_daok = 0, cnt_ddok = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        obs_grants.delete();
        cnt_iaok = 0; cnt_idok = 0; cnt_daok = 0; cnt_ddok = 0;
    endtask

    task automatic check_outputs();
        bit ri, rd;
        logic        e_wr;
        logic [1:0]  e_size;
        logic [31:0] e_addr, e_wdata;
        if (!resetn) begin
            m_owner = 0; m_acc = 1'b0; m_streak = 0;
        end
        ri = (m_owner == 1) && !m_acc;
        rd = (m_owner == 2) && !m_acc;
        e_wr    = ri ? inst_wr    : (rd ? data_wr    : 1'b0);
        e_size  = ri ? inst_size  : (rd ? data_size  : 2'd0);
        e_addr  = ri ? inst_addr  : (rd ? data_addr  : 32'd0);
        e_wdata = ri ? inst_wdata : (rd ? data_wdata : 32'd0);
        check("mem_req", 32'(mem_req), 32'(ri | rd));
        check("mem_wr", 32'(mem_wr), 32'(e_wr));
        check("mem_size", 32'(mem_size), 32'(e_size));
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
        check("inst_addr_ok", 32'(inst_addr_ok), 32'(ri && mem_addr_ok));
        check("data_addr_ok", 32'(data_addr_ok), 32'(rd && mem_addr_ok));
        check("inst_data_ok", 32'(inst_data_ok), 32'((m_owner == 1) && m_acc && mem_data_ok));
        check("data_data_ok", 32'(data_data_ok), 32'((m_owner == 2) && m_acc && mem_data_ok));
        check("inst_rdata", inst_rdata, mem_rdata);
        check("data_rdata", data_rdata, mem_rdata);
        if (inst_addr_ok === 1'b1) begin obs_grants.push_back(1); cnt_iaok++; end
        if (data_addr_ok === 1'b1) begin obs_grants.push_back(2); cnt_daok++; end
        if (inst_data_ok === 1'b1) cnt_idok++;
        if (data_data_ok === 1'b1) cnt_ddok++;
    endtask

    task automatic model_step();
        if (!resetn) return;
        if (m_owner == 0) begin
            if (data_req && !(inst_req && m_streak >= int'(MAXS))) begin
                m_owner  = 2;
                m_streak = inst_req ? m_streak + 1 : 0;
            end else if (inst_req) begin
                m_owner  = 1;
                m_streak = 0;
            end
        end else if (!m_acc) begin
            if (mem_addr_ok) m_acc = 1'b1;
        end else if (mem_data_ok) begin
            m_owner = 0;
            m_acc   = 1'b0;
        end
    endtask

    // Called right after a negedge with inputs set; returns at the next negedge.
    task automatic step();
        bit drop_i, drop_d;
        #1;
        check_outputs();
        drop_i = resetn && (m_owner == 1) && !m_acc && mem_addr_ok;
        drop_d = resetn && (m_owner == 2) && !m_acc && mem_addr_ok;
        model_step();
        @(negedge clk);
        if (drop_i && !keep_i) inst_req = 1'b0;
        if (drop_d && !keep_d) data_req = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int exp3[10];
        int exp2[2];
        exp3 = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        exp2 = '{2, 1};

        resetn = 1'b0;
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        step(); step();
        resetn = 1'b1;
        idle_gap(2);

        // 1: lone fetch with delayed address accept
        clear_obs();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000; inst_wr = 1'b0; inst_size = 2'd2;
        step();
        step(); step();
        mem_addr_ok = 1'b1; step();
        mem_addr_ok = 1'b0; step();
        mem_data_ok = 1'b1; mem_rdata = 32'h3C01_0000;
        #1;
        check("t1_rdata", inst_rdata, 32'h3C01_0000);
        check("t1_data_ok_now", 32'(inst_data_ok), 32'd1);
        step();
        idle_gap(2);
        check("t1_addr_ok_pulses", 32'(cnt_iaok), 32'd1);
        check("t1_data_ok_pulses", 32'(cnt_idok), 32'd1);

        // 2: simultaneous requests, data first
        clear_obs();
        inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0100;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        for (int i = 0; i < 6; i++) step();
        idle_gap(1);
        check("t2_grant_count", 32'(obs_grants.size()), 32'd2);
        for (int i = 0; i < 2 && i < obs_grants.size(); i++)
            check("t2_grant_order", 32'(obs_grants[i]), 32'(exp2[i]));

        // 3: data hogging while fetch waits
        clear_obs();
        keep_i = 1'b1; keep_d = 1'b1;
        inst_req = 1'b1; data_req = 1'b1;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        for (int i = 0; i < 30; i++) step();
        keep_i = 1'b0; keep_d = 1'b0;
        inst_req = 1'b0; data_req = 1'b0;
        idle_gap(2);
        check("t3_grant_count", 32'(obs_grants.size()), 32'd10);
        for (int i = 0; i < 10 && i < obs_grants.size(); i++)
            check("t3_grant_seq", 32'(obs_grants[i]), 32'(exp3[i]));

        // 4: data store fields reach the port
        clear_obs();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
        data_addr = 32'h1FAF_0000; data_wdata = 32'hDEAD_BEEF;
        step();
        #1;
        check("t4_mem_req", 32'(mem_req), 32'd1);
        check("t4_mem_wr", 32'(mem_wr), 32'd1);
        check("t4_mem_size", 32'(mem_size), 32'd2);
        check("t4_mem_addr", mem_addr, 32'h1FAF_0000);
        check("t4_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_addr_ok = 1'b1; step();
        mem_addr_ok = 1'b0; step();
        mem_data_ok = 1'b1; step();
        idle_gap(2);
        check("t4_data_ok_pulses", 32'(cnt_ddok), 32'd1);
        data_wr = 1'b0;

        // 5: reset while awaiting the fetch response
        clear_obs();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        step();
        mem_addr_ok = 1'b1; step();
        mem_addr_ok = 1'b0;
        resetn = 1'b0;
        mem_data_ok = 1'b1;
        step(); step();
        resetn = 1'b1;
        step();
        idle_gap(2);
        check("t5_addr_ok_pulses", 32'(cnt_iaok), 32'd1);
        check("t5_data_ok_dropped", 32'(cnt_idok), 32'd0);

        // 6: spurious data_ok in IDLE, addr_ok+data_ok together in REQ_I
        clear_obs();
        mem_data_ok = 1'b1;
        step(); step(); step();
        check("t6_spurious", 32'(cnt_idok + cnt_ddok), 32'd0);
        inst_req = 1'b1; mem_addr_ok = 1'b1;
        step();
        #1;
        check("t6_req_i_no_data_ok", 32'(inst_data_ok), 32'd0);
        step(); step();
        idle_gap(2);
        check("t6_addr_ok_pulses", 32'(cnt_iaok), 32'd1);
        check("t6_data_ok_pulses", 32'(cnt_idok), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (!inst_req && $urandom_range(2) == 0) begin
                inst_req = 1'b1; inst_wr = ($urandom_range(9) == 0);
                inst_size = 2'($urandom_range(2)); inst_addr = $urandom; inst_wdata = $urandom;
            end
            if (!data_req && $urandom_range(2) == 0) begin
                data_req = 1'b1; data_wr = 1'($urandom_range(1));
                data_size = 2'($urandom_range(2)); data_addr = $urandom; data_wdata = $urandom;
            end
            mem_addr_ok = 1'($urandom_range(1));
            mem_data_ok = 1'($urandom_range(1));
            mem_rdata = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
